// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage controller splitting 32-bit loads/stores into two 16-bit SRAM half-word accesses.
// Optional macro MEM_ADDR_CHECK_EN: out-of-window addresses skip the SRAM and raise addr_err_out for one cycle.
module mem_stage_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_BASE    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_in,
    input  logic        mem_w_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dest_in,
    output logic        wb_en_out,
    output logic        mem_r_out,
    output logic [31:0] alu_res_out,
    output logic [3:0]  dest_out,
    output logic [31:0] mem_res_out,
    output logic        freeze_out,
`ifdef MEM_ADDR_CHECK_EN
    output logic        addr_err_out,
`endif
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] mem_res_q, mem_res_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic        sram_dq_oe_q, sram_dq_oe_d;
    logic        req, last, active;
    logic [16:0] word;
`ifdef MEM_ADDR_CHECK_EN
    logic        err_q, err_d;
    logic        range_err;
    assign range_err = ({1'b0, alu_res_in} < 33'(MEM_BASE)) ||
                       ({1'b0, alu_res_in} >= 33'(MEM_BASE) + 33'd524288);
    assign addr_err_out = err_q;
`endif

    assign wb_en_out   = wb_en_in;
    assign mem_r_out   = mem_r_in;
    assign alu_res_out = alu_res_in;
    assign dest_out    = dest_in;
    assign mem_res_out = mem_res_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_dq_oe  = sram_dq_oe_q;

    assign req  = mem_r_in | mem_w_in;
    assign last = cnt_q == 3'(WAIT_CYCLES);
    // SRAM word offset; the truncating shift drops byte-offset bits and wraps into the 18-bit space
    assign word = 17'((alu_res_in - 32'(MEM_BASE)) >> 2);
    assign freeze_out = (state_q == IDLE && req) || state_q == LO || state_q == HI;

    // Next-state, capture of the request and read-data assembly; SRAM pins are precomputed from the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        lo_d      = lo_q;
        mem_res_d = mem_res_q;
`ifdef MEM_ADDR_CHECK_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = word;
                    wdata_d = val_rm_in;
                    wr_d    = mem_w_in;
                    cnt_d   = 3'd0;
                    state_d = LO;
`ifdef MEM_ADDR_CHECK_EN
                    if (range_err) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!mem_w_in) mem_res_d = 32'd0;
                    end
`endif
                end
            end
            LO: begin
                if (last && !wr_q) lo_d = sram_rdata;
                cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
                state_d = last ? HI : LO;
            end
            HI: begin
                if (last && !wr_q) mem_res_d = {sram_rdata, lo_q};
                cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
                state_d = last ? DONE : HI;
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
        active       = state_d == LO || state_d == HI;
        sram_addr_d  = active ? {addr_d, state_d == HI} : 18'd0;
        sram_wdata_d = (active && wr_d) ? (state_d == HI ? wdata_d[31:16] : wdata_d[15:0]) : 16'd0;
        sram_we_n_d  = !(active && wr_d);
        sram_dq_oe_d = active && wr_d;
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            addr_q       <= 17'd0;
            wdata_q      <= 32'd0;
            wr_q         <= 1'b0;
            lo_q         <= 16'd0;
            mem_res_q    <= 32'd0;
            sram_addr_q  <= 18'd0;
            sram_wdata_q <= 16'd0;
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            lo_q         <= lo_d;
            mem_res_q    <= mem_res_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_dq_oe_q <= sram_dq_oe_d;
`ifdef MEM_ADDR_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: scoreboard bench for mem_stage_sram_ctrl with behavioural SRAM models.
module tb_mem_stage_sram_ctrl;
    localparam int W = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wb_en_in, mem_r_in, mem_w_in;
    logic [31:0] alu_res_in, val_rm_in;
    logic [3:0]  dest_in;
    logic        wb_en_out, mem_r_out, freeze_out;
    logic [31:0] alu_res_out, mem_res_out;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_dq_oe, sram_we_n;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err_out;
`endif

    logic        r0;
    logic [31:0] alu0;
    logic        wb0_out, mr0_out, freeze0;
    logic [31:0] alu0_out, mem_res0;
    logic [3:0]  dest0_out;
    logic [17:0] sram0_addr;
    logic [15:0] sram0_wdata, sram0_rdata;
    logic        sram0_oe, sram0_we_n;
`ifdef MEM_ADDR_CHECK_EN
    logic        err0;
`endif

    logic [15:0] mem  [1024];
    logic [15:0] mem0 [1024];
    assign sram_rdata  = mem[sram_addr[9:0]];
    assign sram0_rdata = mem0[sram0_addr[9:0]];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[9:0]] <= sram_wdata;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .MEM_BASE(1024)) u_dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_in(mem_r_in), .mem_w_in(mem_w_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .wb_en_out(wb_en_out), .mem_r_out(mem_r_out), .alu_res_out(alu_res_out),
        .dest_out(dest_out), .mem_res_out(mem_res_out), .freeze_out(freeze_out),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err_out(addr_err_out),
`endif
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(0), .MEM_BASE(1024)) u_dut0 (
        .clk(clk), .rst(rst),
        .wb_en_in(1'b0), .mem_r_in(r0), .mem_w_in(1'b0),
        .alu_res_in(alu0), .val_rm_in(32'd0), .dest_in(4'd0),
        .wb_en_out(wb0_out), .mem_r_out(mr0_out), .alu_res_out(alu0_out),
        .dest_out(dest0_out), .mem_res_out(mem_res0), .freeze_out(freeze0),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err_out(err0),
`endif
        .sram_addr(sram0_addr), .sram_wdata(sram0_wdata), .sram_rdata(sram0_rdata),
        .sram_dq_oe(sram0_oe), .sram_we_n(sram0_we_n)
    );

    int vecs = 0;
    int errs = 0;
    logic [33:0] wq [$];
    logic [31:0] rq [$];
    logic [31:0] q0 [$];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] exp_res = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'hA5C3;
    endfunction

    // Every SRAM write beat must match the next expected beat; read beats must not drive the bus
    always @(negedge clk) begin
        if (rst && !sram_we_n) begin
            if (wq.size() == 0) chk("wr_extra", 32'(wq.size()), 32'd1);
            else begin
                logic [33:0] e;
                e = wq.pop_front();
                chk("wr_addr", 32'(sram_addr), 32'(e[33:16]));
                chk("wr_data", 32'(sram_wdata), 32'(e[15:0]));
                chk("wr_oe", 32'(sram_dq_oe), 32'd1);
            end
        end
        if (rst && freeze_out && sram_we_n) chk("rd_oe", 32'(sram_dq_oe), 32'd0);
    end

    task automatic push_beats(input logic [16:0] w, input logic [31:0] d, input int halves);
        for (int h = 0; h < halves; h++)
            for (int k = 0; k <= W; k++)
                wq.push_back({w, h[0], h[0] ? d[31:16] : d[15:0]});
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic [16:0] w;
        logic [31:0] e;
        w = 17'((a - 32'd1024) >> 2);
        if (wr) begin
            push_beats(w, d, 2);
            ref_mem[w] = d;
        end
        e = (rd && !wr) ? ref_mem[w] : exp_res;
        exp_res = e;
        rq.push_back(e);
        @(negedge clk);
        mem_r_in = rd; mem_w_in = wr; alu_res_in = a; val_rm_in = d;
        wb_en_in = rd; dest_in = a[5:2];
        #1;
        chk("pt_alu", alu_res_out, a);
        chk("pt_ctl", {26'd0, wb_en_out, mem_r_out, dest_out}, {26'd0, rd, rd, a[5:2]});
        n = 0;
        while (freeze_out && n < 40) begin
            n++;
            @(posedge clk); #1;
            if (n == 1) begin
                mem_r_in = 1'b0; mem_w_in = 1'b0; alu_res_in = ~a; val_rm_in = ~d;
            end
        end
        chk("freeze_len", 32'(n), 32'(2 * (W + 1) + 1));
        chk("done_res", mem_res_out, rq.pop_front());
        chk("done_addr", 32'(sram_addr), 32'd0);
        chk("done_wen", 32'(sram_we_n), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ws [4];
        ws = '{0, 3, 200, 77};
        for (int i = 0; i < 1024; i++) mem0[i] = pat(i);
        wb_en_in = 0; mem_r_in = 0; mem_w_in = 0; alu_res_in = 0; val_rm_in = 0; dest_in = 0;
        r0 = 0; alu0 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freeze", 32'(freeze_out), 32'd0);
        chk("rst_wen", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wdata", 32'(sram_wdata), 32'd0);
        chk("rst_res", mem_res_out, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        acc(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        acc(1'b1, 1'b0, 32'd1028, 32'd0);
        acc(1'b1, 1'b0, 32'd1031, 32'd0);
        acc(1'b1, 1'b1, 32'd1028, 32'h0BADF00D);
        acc(1'b1, 1'b0, 32'd1028, 32'd0);
        acc(1'b0, 1'b1, 32'd1024 + 32'd524284, 32'h5A5AA5A5);
        acc(1'b1, 1'b0, 32'd1024 + 32'd524284, 32'd0);
`ifndef MEM_ADDR_CHECK_EN
        acc(1'b0, 1'b1, 32'd1024 + 32'd524288 + 32'd8, 32'hCAFEBABE);
        acc(1'b1, 1'b0, 32'd1032, 32'd0);
`else
        begin
            int n;
            @(negedge clk);
            mem_r_in = 1'b1; alu_res_in = 32'd512;
            #1 n = 0;
            while (freeze_out && n < 40) begin
                n++;
                @(posedge clk); #1;
                mem_r_in = 1'b0;
            end
            chk("err_freeze", 32'(n), 32'd1);
            chk("err_flag", 32'(addr_err_out), 32'd1);
            chk("err_res", mem_res_out, 32'd0);
            chk("err_wen", 32'(sram_we_n), 32'd1);
            @(posedge clk); #1;
            chk("err_flag_end", 32'(addr_err_out), 32'd0);
            exp_res = 32'd0;
        end
`endif

        for (int k = 0; k < 4; k++) q0.push_back({pat(2 * ws[k] + 1), pat(2 * ws[k])});
        @(negedge clk);
        r0 = 1'b1; alu0 = 32'd1024 + 32'(4 * ws[0]);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                #1 chk("b2b_frz", 32'(freeze0), 32'(c < 3));
                if (c == 3) begin
                    chk("b2b_res", mem_res0, q0.pop_front());
                    if (k == 3) r0 = 1'b0;
                    else alu0 = 32'd1024 + 32'(4 * ws[k + 1]);
                end
                @(negedge clk);
            end
        end

        push_beats(17'd100, 32'h12345678, 1);
        @(negedge clk);
        mem_w_in = 1'b1; alu_res_in = 32'd1424; val_rm_in = 32'h12345678;
        @(posedge clk); #1;
        mem_w_in = 1'b0;
        repeat (W + 1) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_wen", 32'(sram_we_n), 32'd1);
        chk("abort_freeze", 32'(freeze_out), 32'd0);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_res", mem_res_out, 32'd0);
        exp_res = 32'd0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("resume_freeze", 32'(freeze_out), 32'd0);
        chk("resume_wen", 32'(sram_we_n), 32'd1);
        acc(1'b1, 1'b0, 32'd1028, 32'd0);

        chk("wq_empty", 32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
